// File: rtl/ts_avg_filter_if.sv
// Sample input and conditioned-output bundle for the dual-channel temperature averager.
// master drives samples and observes results; slave is the filter side.
interface ts_avg_filter_if;
    logic       sample_valid;
    logic       sample_ch;
    logic [7:0] sample_data;
    logic [7:0] ts1;
    logic [7:0] ts2;
    logic       ts1_valid;
    logic       ts2_valid;
    logic       upd;
    logic       upd_ch;

    modport master (
        output sample_valid, sample_ch, sample_data,
        input  ts1, ts2, ts1_valid, ts2_valid, upd, upd_ch
    );

    modport slave (
        input  sample_valid, sample_ch, sample_data,
        output ts1, ts2, ts1_valid, ts2_valid, upd, upd_ch
    );
endinterface

// File: rtl/ts_avg_filter.sv
// Dual-channel moving-average conditioner: per-channel window of 2**LOG_DEPTH samples,
// two-stage update (window/sum, then output), and an idle timeout that flushes a silent channel.
module ts_avg_filter #(
    parameter int unsigned LOG_DEPTH = 2,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input logic            clk,
    input logic            rst,
    ts_avg_filter_if.slave bus
);
    localparam int unsigned   DEPTH    = 1 << LOG_DEPTH;
    localparam int unsigned   SW       = 8 + LOG_DEPTH;
    localparam int unsigned   FW       = LOG_DEPTH + 1;
    localparam logic [FW-1:0] FillFull = FW'(DEPTH);

    logic [7:0]           win_q  [2][DEPTH];
    logic [7:0]           win_d  [2][DEPTH];
    logic [SW-1:0]        sum_q  [2];
    logic [SW-1:0]        sum_d  [2];
    logic [FW-1:0]        fill_q [2];
    logic [FW-1:0]        fill_d [2];
    logic [LOG_DEPTH-1:0] wp_q   [2];
    logic [LOG_DEPTH-1:0] wp_d   [2];
    logic [15:0]          idle_q [2];
    logic [15:0]          idle_d [2];
    logic [7:0]           ts_q   [2];
    logic [7:0]           ts_d   [2];
    logic [1:0]           tsv_q, tsv_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_ch_q, s1_ch_d;
    logic                 upd_q, upd_d;
    logic                 upd_ch_q, upd_ch_d;

    always_comb begin
        win_d    = win_q;
        sum_d    = sum_q;
        fill_d   = fill_q;
        wp_d     = wp_q;
        idle_d   = idle_q;
        ts_d     = ts_q;
        tsv_d    = tsv_q;
        s1_vld_d = bus.sample_valid;
        s1_ch_d  = bus.sample_ch;
        upd_d    = s1_vld_q;
        upd_ch_d = s1_vld_q & s1_ch_q;

        // Stage 2 reads the sum/fill that stage 1 registered on the previous edge.
        if (s1_vld_q && (fill_q[s1_ch_q] == FillFull)) begin
            ts_d[s1_ch_q]  = sum_q[s1_ch_q][SW-1:LOG_DEPTH];
            tsv_d[s1_ch_q] = 1'b1;
        end

        for (int c = 0; c < 2; c++) begin
            if (bus.sample_valid && (bus.sample_ch == c[0])) begin
                win_d[c][wp_q[c]] = bus.sample_data;
                sum_d[c]  = sum_q[c] + SW'(bus.sample_data) - SW'(win_q[c][wp_q[c]]);
                fill_d[c] = (fill_q[c] == FillFull) ? fill_q[c] : fill_q[c] + FW'(1);
                wp_d[c]   = wp_q[c] + LOG_DEPTH'(1);
                idle_d[c] = '0;
            end else if (idle_q[c] != TIMEOUT) begin
                idle_d[c] = idle_q[c] + 16'd1;
                // Flush fires only on the edge the counter reaches TIMEOUT; it then saturates.
                if (idle_q[c] == TIMEOUT - 16'd1) begin
                    win_d[c]  = '{default: '0};
                    sum_d[c]  = '0;
                    fill_d[c] = '0;
                    wp_d[c]   = '0;
                    tsv_d[c]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q    <= '{default: '0};
            sum_q    <= '{default: '0};
            fill_q   <= '{default: '0};
            wp_q     <= '{default: '0};
            idle_q   <= '{default: '0};
            ts_q     <= '{default: '0};
            tsv_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= 1'b0;
            upd_q    <= 1'b0;
            upd_ch_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
            wp_q     <= wp_d;
            idle_q   <= idle_d;
            ts_q     <= ts_d;
            tsv_q    <= tsv_d;
            s1_vld_q <= s1_vld_d;
            s1_ch_q  <= s1_ch_d;
            upd_q    <= upd_d;
            upd_ch_q <= upd_ch_d;
        end
    end

    assign bus.ts1       = ts_q[0];
    assign bus.ts2       = ts_q[1];
    assign bus.ts1_valid = tsv_q[0];
    assign bus.ts2_valid = tsv_q[1];
    assign bus.upd       = upd_q;
    assign bus.upd_ch    = upd_ch_q;
endmodule

// File: tb/tb_ts_avg_filter.sv
// Scoreboard bench for ts_avg_filter: each driven sample pushes its expected upd result,
// a forked monitor pops and compares on every upd strobe.
module tb_ts_avg_filter;
    localparam int DEPTH = 4;

    typedef struct {
        logic       ch;
        logic [7:0] ts;
        logic       vld;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   upd_cnt0;
    int   upd_cnt1;

    exp_t       sb [$];
    logic [7:0] h0 [$];
    logic [7:0] h1 [$];
    logic [7:0] m_ts [2];

    ts_avg_filter_if bus ();

    ts_avg_filter #(
        .LOG_DEPTH (2),
        .TIMEOUT   (16'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: keep the last DEPTH samples and average them directly.
    task automatic model_push(input logic ch, input logic [7:0] d);
        exp_t e;
        int   s;
        bit   full;
        s = 0;
        if (!ch) begin
            h0.push_back(d);
            if (h0.size() > DEPTH) void'(h0.pop_front());
            foreach (h0[i]) s += int'(h0[i]);
            full = (h0.size() == DEPTH);
        end else begin
            h1.push_back(d);
            if (h1.size() > DEPTH) void'(h1.pop_front());
            foreach (h1[i]) s += int'(h1[i]);
            full = (h1.size() == DEPTH);
        end
        if (full) m_ts[ch] = 8'(s / DEPTH);
        e.ch  = ch;
        e.ts  = m_ts[ch];
        e.vld = full;
        sb.push_back(e);
    endtask

    task automatic drive(input logic ch, input logic [7:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_ch    = ch;
        bus.sample_data  = d;
        model_push(ch, d);
    endtask

    task automatic drive_idle();
        bus.sample_valid = 1'b0;
        bus.sample_ch    = 1'b0;
        bus.sample_data  = 8'd0;
    endtask

    task automatic drain();
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_missing_upd: pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({bus.ts1, bus.ts2, bus.ts1_valid, bus.ts2_valid, bus.upd, bus.upd_ch} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: ts1=%0d ts2=%0d v1=%b v2=%b upd=%b ch=%b required all 0",
                     bus.ts1, bus.ts2, bus.ts1_valid, bus.ts2_valid, bus.upd, bus.upd_ch);
        end
    endtask

    task automatic test_fill_window();
        int c0;
        int c1;
        c0 = upd_cnt0;
        c1 = upd_cnt1;
        @(negedge clk); drive(1'b0, 8'd20);
        @(negedge clk); drive(1'b0, 8'd30);
        @(negedge clk); drive(1'b0, 8'd40);
        @(negedge clk); drive(1'b0, 8'd50);
        @(negedge clk); drive_idle();
        checks++;
        if (bus.ts1_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_valid_early: ts1_valid=%b required=0", bus.ts1_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.ts1_valid !== 1'b1 || bus.ts1 !== 8'd35 || bus.ts2_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_first_avg: ts1=%0d v1=%b v2=%b required ts1=35 v1=1 v2=0",
                     bus.ts1, bus.ts1_valid, bus.ts2_valid);
        end
        drain();
        checks++;
        if (upd_cnt0 - c0 != 4 || upd_cnt1 - c1 != 0) begin
            errors++;
            $display("FAIL fill_upd_count: ch0=%0d ch1=%0d required ch0=4 ch1=0",
                     upd_cnt0 - c0, upd_cnt1 - c1);
        end
    endtask

    task automatic test_slide();
        @(negedge clk); drive(1'b0, 8'd70);
        drain();
        checks++;
        if (bus.ts1 !== 8'd47 || bus.ts1_valid !== 1'b1) begin
            errors++;
            $display("FAIL slide_avg: ts1=%0d v1=%b required ts1=47 v1=1", bus.ts1, bus.ts1_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (bus.upd !== 1'b1 || bus.upd_ch !== 1'((i - 2) % 2)) begin
                    errors++;
                    $display("FAIL b2b_upd[%0d]: upd=%b ch=%b required upd=1 ch=%0d",
                             i, bus.upd, bus.upd_ch, (i - 2) % 2);
                end
            end
            if (i % 2 == 0) drive(1'b0, 8'd10);
            else            drive(1'b1, 8'd255);
        end
    endtask

    task automatic test_timeout_flush();
        // Last ch1 accept is the edge right after back_to_back's final drive.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 16) begin
                checks++;
                if (bus.ts2_valid !== 1'b1 || bus.ts2 !== 8'd255) begin
                    errors++;
                    $display("FAIL flush_before: ts2=%0d v2=%b required ts2=255 v2=1",
                             bus.ts2, bus.ts2_valid);
                end
            end
            drive(1'b0, 8'd10);
        end
        @(negedge clk);
        checks++;
        if (bus.ts2_valid !== 1'b0 || bus.ts2 !== 8'd255 || bus.ts1 !== 8'd10 ||
            bus.ts1_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_edge: ts2=%0d v2=%b ts1=%0d v1=%b required 255 0 10 1",
                     bus.ts2, bus.ts2_valid, bus.ts1, bus.ts1_valid);
        end
        h1.delete();
        drive(1'b1, 8'd40);
        @(negedge clk); drive(1'b1, 8'd80);
        @(negedge clk); drive(1'b1, 8'd120);
        drain();
        checks++;
        if (bus.ts2_valid !== 1'b0 || bus.ts2 !== 8'd255) begin
            errors++;
            $display("FAIL refill_partial: ts2=%0d v2=%b required ts2=255 v2=0",
                     bus.ts2, bus.ts2_valid);
        end
        @(negedge clk); drive(1'b1, 8'd160);
        drain();
        checks++;
        if (bus.ts2_valid !== 1'b1 || bus.ts2 !== 8'd100) begin
            errors++;
            $display("FAIL refill_full: ts2=%0d v2=%b required ts2=100 v2=1",
                     bus.ts2, bus.ts2_valid);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 1'b0;
        bus.sample_data  = 8'd200;
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        h0.delete();
        h1.delete();
        m_ts[0] = 8'd0;
        m_ts[1] = 8'd0;
        checks++;
        if ({bus.ts1, bus.ts2, bus.ts1_valid, bus.ts2_valid, bus.upd, bus.upd_ch} !== 20'd0) begin
            errors++;
            $display("FAIL midreset_outputs: ts1=%0d ts2=%0d v1=%b v2=%b upd=%b required all 0",
                     bus.ts1, bus.ts2, bus.ts1_valid, bus.ts2_valid, bus.upd);
        end
        @(negedge clk);
        checks++;
        if (bus.upd !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_upd: upd=%b required=0", bus.upd);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, 8'(100 + i));
        end
        drain();
        checks++;
        if (bus.ts1_valid !== 1'b1 || bus.ts1 !== 8'd101 || bus.ts2_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_refill: ts1=%0d v1=%b v2=%b required 101 1 0",
                     bus.ts1, bus.ts1_valid, bus.ts2_valid);
        end
    endtask

    task automatic test_timeout_boundary();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b1, 8'(8 * i));
        end
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            drive_idle();
        end
        @(negedge clk);
        checks++;
        if (bus.ts2_valid !== 1'b1 || bus.ts2 !== 8'd20) begin
            errors++;
            $display("FAIL boundary_before: ts2=%0d v2=%b required ts2=20 v2=1",
                     bus.ts2, bus.ts2_valid);
        end
        drive(1'b1, 8'd40);
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus.ts2_valid !== 1'b1) begin
            errors++;
            $display("FAIL boundary_no_flush: ts2_valid=%b required=1", bus.ts2_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.ts2_valid !== 1'b1 || bus.ts2 !== 8'd28) begin
            errors++;
            $display("FAIL boundary_update: ts2=%0d v2=%b required ts2=28 v2=1",
                     bus.ts2, bus.ts2_valid);
        end
        drain();
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        errors   = 0;
        upd_cnt0 = 0;
        upd_cnt1 = 0;
        m_ts[0]  = 8'd0;
        m_ts[1]  = 8'd0;
        rst      = 1'b0;
        drive_idle();

        fork
            forever begin
                @(negedge clk);
                if (bus.upd === 1'b1) begin
                    if (bus.upd_ch === 1'b0) upd_cnt0++;
                    else                     upd_cnt1++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_upd: ch=%b required no upd", bus.upd_ch);
                    end else begin
                        e = sb.pop_front();
                        if (bus.upd_ch !== e.ch ||
                            (e.ch ? bus.ts2 : bus.ts1) !== e.ts ||
                            (e.ch ? bus.ts2_valid : bus.ts1_valid) !== e.vld) begin
                            errors++;
                            $display("FAIL sb_upd: ch=%b ts=%0d v=%b required ch=%b ts=%0d v=%b",
                                     bus.upd_ch, e.ch ? bus.ts2 : bus.ts1,
                                     e.ch ? bus.ts2_valid : bus.ts1_valid, e.ch, e.ts, e.vld);
                        end
                    end
                end else if (bus.upd_ch !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_ch_idle: upd_ch=%b required=0", bus.upd_ch);
                end
            end
        join_none

        test_reset();
        test_fill_window();
        test_slide();
        test_back_to_back();
        test_timeout_flush();
        drain();
        test_mid_reset();
        test_timeout_boundary();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
